traffic_intersection_ctrl: RTL and testbench

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

---
 rtl/traffic_intersection_ctrl.sv | 170 +++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Round-robin traffic intersection controller with fixed-length GREEN/YELLOW/ALL_RED phases.
// Optional pedestrian WALK phase is compiled in when PED_WALK_EN is defined.
module traffic_intersection_ctrl #(
  parameter int N_DIR          = 4,
  parameter int GREEN_CYCLES   = 8,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int WALK_CYCLES    = 5,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DIR-1:0] req,
  input  logic             ped_req,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic             walk,
  output logic [2:0]       active_idx,
  output logic [1:0]       phase
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_WALK    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LOAD   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LOAD = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD    = CNT_W'(WALK_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         r_active;
  logic [2:0]         w_active_nxt;
  logic               w_walk_entry;
  logic               w_ped_pending;

  logic [2*N_DIR-1:0] w_req2;
  logic [3:0]         w_shamt;
  logic [N_DIR-1:0]   w_rot;
  logic               w_found;
  logic [3:0]         w_off;
  logic [3:0]         w_sum;
  logic [2:0]         w_pick;
  logic [N_DIR-1:0]   w_onehot;

  // Rotate requests so bit k is approach (active+1+k) mod N_DIR; the lowest set bit wins.
  assign w_req2  = {req, req};
  assign w_shamt = {1'b0, r_active} + 4'd1;
  assign w_rot   = N_DIR'(w_req2 >> w_shamt);

  always_comb begin
    w_found = 1'b0;
    w_off   = 4'd0;
    for (int k = N_DIR - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = 4'(k);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_sum  = w_shamt + w_off;
  assign w_pick = (w_sum >= 4'(N_DIR)) ? 3'(w_sum - 4'(N_DIR)) : 3'(w_sum);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    w_active_nxt = r_active;
    w_walk_entry = 1'b0;
    if (r_cnt == '0) begin
      case (r_state)
        ST_ALL_RED: begin
          if (w_ped_pending) begin
            w_state_nxt  = ST_WALK;
            w_cnt_nxt    = WALK_LOAD;
            w_walk_entry = 1'b1;
          end else if (w_found) begin
            w_state_nxt  = ST_GREEN;
            w_cnt_nxt    = GREEN_LOAD;
            w_active_nxt = w_pick;
          end else begin
            w_cnt_nxt    = ALL_RED_LOAD;
          end
        end
        ST_GREEN: begin
          w_state_nxt = ST_YELLOW;
          w_cnt_nxt   = YELLOW_LOAD;
        end
        ST_YELLOW, ST_WALK: begin
          w_state_nxt = ST_ALL_RED;
          w_cnt_nxt   = ALL_RED_LOAD;
        end
        default: begin
          w_state_nxt = ST_ALL_RED;
          w_cnt_nxt   = ALL_RED_LOAD;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_ALL_RED;
      r_cnt    <= ALL_RED_LOAD;
      r_active <= 3'(N_DIR - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_active <= w_active_nxt;
    end
  end

`ifdef PED_WALK_EN
  logic r_ped;

  // A request coinciding with WALK entry stays latched and earns the next walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped <= 1'b0;
    end else begin
      r_ped <= ped_req | (r_ped & ~w_walk_entry);
    end
  end

  assign w_ped_pending = r_ped;
  assign walk          = (r_state == ST_WALK);
`else
  logic w_unused_ped;

  assign w_unused_ped  = ped_req ^ w_walk_entry;
  assign w_ped_pending = 1'b0;
  assign walk          = 1'b0;
`endif

  assign w_onehot = {{(N_DIR-1){1'b0}}, 1'b1} << r_active;

  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    case (r_state)
      ST_GREEN: begin
        green = w_onehot;
        red   = ~w_onehot;
      end
      ST_YELLOW: begin
        yellow = w_onehot;
        red    = ~w_onehot;
      end
      default: begin
        red = '1;
      end
    endcase
  end

  assign active_idx = r_active;
  assign phase      = r_state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench: phase-level reference model compared every cycle plus directed literal checks.
module tb_traffic_intersection_ctrl;
  localparam int N  = 4;
  localparam int G  = 8;
  localparam int Y  = 3;
  localparam int AR = 2;
  localparam int W  = 5;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         ped_req;
  logic [N-1:0] red, yellow, green;
  logic         walk;
  logic [2:0]   active_idx;
  logic [1:0]   phase;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .N_DIR(N), .GREEN_CYCLES(G), .YELLOW_CYCLES(Y),
    .ALL_RED_CYCLES(AR), .WALK_CYCLES(W), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .ped_req(ped_req),
    .red(red), .yellow(yellow), .green(green), .walk(walk),
    .active_idx(active_idx), .phase(phase)
  );

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase (0 AR, 1 G, 2 Y, 3 WALK), clocks left in phase, served index, ped latch.
  int m_ph, m_left, m_idx, m_j;
  bit m_ped, m_found, m_entered;

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_left = AR; m_idx = N - 1; m_ped = 1'b0;
    end else begin
      m_entered = 1'b0;
      if (m_left > 1) begin
        m_left = m_left - 1;
      end else if (m_ph == 0) begin
        if (PED && m_ped) begin
          m_ph = 3; m_left = W; m_entered = 1'b1;
        end else begin
          m_found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            m_j = (m_idx + k) % N;
            if (!m_found && req[m_j]) begin
              m_found = 1'b1; m_idx = m_j;
            end
          end
          if (m_found) begin m_ph = 1; m_left = G; end
          else m_left = AR;
        end
      end else if (m_ph == 1) begin
        m_ph = 2; m_left = Y;
      end else begin
        m_ph = 0; m_left = AR;
      end
      m_ped = PED && (ped_req || (m_ped && !m_entered));
    end
  end

  int serve_log[$];
  bit bad02;
  int prev_phase = 0;

  // Every-cycle comparison against the model plus lamp sanity rules.
  always @(negedge clk) begin
    int e_red, e_yel, e_grn, nonred;
    if (chk_en) begin
      e_grn = (m_ph == 1) ? (1 << m_idx) : 0;
      e_yel = (m_ph == 2) ? (1 << m_idx) : 0;
      e_red = (m_ph == 1 || m_ph == 2) ? ((~(1 << m_idx)) & 15) : 15;
      chk("red", 32'(red), e_red);
      chk("yellow", 32'(yellow), e_yel);
      chk("green", 32'(green), e_grn);
      chk("walk", 32'(walk), (m_ph == 3) ? 1 : 0);
      chk("phase", 32'(phase), m_ph);
      chk("active_idx", 32'(active_idx), m_idx);
      nonred = 0;
      for (int i = 0; i < N; i++) begin
        chk("lamp_onehot", 32'(int'(red[i]) + int'(yellow[i]) + int'(green[i])), 1);
        if (red[i] !== 1'b1) nonred++;
      end
      chk("one_nonred", 32'(nonred <= 1), 1);
      if (phase == 2'd1 && prev_phase != 1) serve_log.push_back(int'(active_idx));
      if (red[0] !== 1'b1 || red[2] !== 1'b1) bad02 = 1'b1;
      prev_phase = int'(phase);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the first negedge after the reset edge (cycle N0).
  task automatic do_reset();
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; ped_req = 1'b0;
    adv(1);
    chk_en = 1'b1;

    // Scenario 1: all approaches requesting.
    reset = 1'b0; req = 4'b1111;
    chk("s1_reset_red", 32'(red), 15);
    chk("s1_reset_grn", 32'(green), 0);
    chk("s1_reset_yel", 32'(yellow), 0);
    chk("s1_reset_walk", 32'(walk), 0);
    chk("s1_reset_phase", 32'(phase), 0);
    chk("s1_reset_idx", 32'(active_idx), 3);
    adv(1); chk("s1_ar2", 32'(phase), 0);
    adv(1); chk("s1_g0_first", 32'(green), 1);
    adv(7); chk("s1_g0_last", 32'(green), 1);
    adv(1); chk("s1_y0_first", 32'(yellow), 1);
    adv(2); chk("s1_y0_last", 32'(yellow), 1);
    adv(1); chk("s1_ar_after_y", 32'(phase), 0);
    adv(1); chk("s1_ar_red", 32'(red), 15);
    adv(1); chk("s1_g1", 32'(green), 2);
    adv(38); chk("s1_ar_before_wrap", 32'(phase), 0);
    adv(1); chk("s1_wrap_g0", 32'(green), 1);
    chk("s1_wrap_idx", 32'(active_idx), 0);

    // Scenario 2: alternating requests 1 and 3.
    do_reset(); req = 4'b1010;
    serve_log.delete(); bad02 = 1'b0;
    adv(50);
    chk("s2_serves", 32'(serve_log.size()), 4);
    chk("s2_serve0", 32'(serve_log[0]), 1);
    chk("s2_serve1", 32'(serve_log[1]), 3);
    chk("s2_serve2", 32'(serve_log[2]), 1);
    chk("s2_serve3", 32'(serve_log[3]), 3);
    chk("s2_0_2_red", 32'(bad02), 0);

    // Scenario 3: idle, then a single late request.
    do_reset(); req = 4'b0000;
    adv(20); chk("s3_idle_phase", 32'(phase), 0);
    req = 4'b0100;
    adv(1); chk("s3_still_ar", 32'(phase), 0);
    adv(1); chk("s3_g2", 32'(green), 4);
    chk("s3_idx2", 32'(active_idx), 2);

    // Scenario 4: pedestrian pulse during green[0].
    do_reset(); req = 4'b1111;
    adv(4); ped_req = 1'b1;
    adv(1); ped_req = 1'b0;
    adv(5); chk("s4_y0", 32'(yellow), 1);
    adv(3); chk("s4_ar", 32'(phase), 0);
    adv(2);
    if (PED) begin
      chk("s4_walk_first", 32'(walk), 1);
      chk("s4_walk_phase", 32'(phase), 3);
      adv(4); chk("s4_walk_last", 32'(walk), 1);
      adv(1); chk("s4_walk_off", 32'(walk), 0);
      adv(2); chk("s4_g1", 32'(green), 2);
    end else begin
      chk("s4_noped_g1", 32'(green), 2);
      chk("s4_noped_walk", 32'(walk), 0);
    end

    // Scenario 5: reset on the 4th clock of green[1].
    do_reset(); req = 4'b1111;
    adv(18); chk("s5_g1_before", 32'(green), 2);
    reset = 1'b1;
    adv(1);
    chk("s5_reset_red", 32'(red), 15);
    chk("s5_reset_phase", 32'(phase), 0);
    reset = 1'b0;
    adv(2); chk("s5_next_g0", 32'(green), 1);
    chk("s5_next_idx", 32'(active_idx), 0);

    adv(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
